// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg -- shared types and constants for the round-robin mux arbiter.
//   DEFAULT_WIDTH : default data width of requesters and output
//   state_e       : output-register occupancy FSM (ST_EMPTY / ST_FULL)
//   src_e         : source tag of the held output word (SRC_A = 0, SRC_B = 1)
package rr_mux_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin grant logic with optional ownership lock.
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request vector, bit 0 = A, bit 1 = B
//   advance    : a transfer happened this cycle for the granted requester
//   lock       : (ARB_LOCK_EN only) lock flag of the transferring requester
//   grant[1:0] : one-hot (or zero) grant, combinational from req and state
// Build option: define ARB_LOCK_EN to add the lock input and ownership state.
module rr_arb2
    import rr_mux_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [1:0] grant
);

    // 1 means B wins the next contention; cleared on reset so A goes first.
    logic       prio_b_q, prio_b_d;
    logic [1:0] eff_req;

`ifdef ARB_LOCK_EN
    logic locked_q, locked_d;
    src_e owner_q,  owner_d;

    // While locked, the non-owner request is masked; an idle owner simply
    // produces no grant rather than handing the bus over.
    always_comb begin
        eff_req = req;
        if (locked_q) begin
            if (owner_q == SRC_A) eff_req = {1'b0, req[0]};
            else                  eff_req = {req[1], 1'b0};
        end
    end

    // Lock state follows the lock flag of each completed transfer.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        if (advance) begin
            locked_d = lock;
            owner_d  = grant[1] ? SRC_B : SRC_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
            owner_q  <= SRC_A;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
        end
    end
`else
    always_comb eff_req = req;
`endif

    always_comb begin
        grant = 2'b00;
        case (eff_req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_b_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves only on a real transfer: after serving A, favour B.
    always_comb prio_b_d = advance ? grant[0] : prio_b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prio_b_q <= 1'b0;
        else       prio_b_q <= prio_b_d;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter -- two requesters round-robin arbitrated into one
// registered output word.
//   clk, reset            : clock, asynchronous active-high reset
//   a_valid_i/a_data_i/a_ready_o : requester A handshake
//   b_valid_i/b_data_i/b_ready_o : requester B handshake
//   y_valid_o/y_data_o/y_ready_i : output handshake
//   y_src_o               : source of held word (0 = A, 1 = B)
//   a_lock_i, b_lock_i    : (ARB_LOCK_EN only) per-requester lock flags
//   dbg_state_o           : current occupancy FSM state
// Handshake: a word moves on any port at a rising clk edge where valid and
// ready are both high. Input readies are combinational from grant and
// can_load (output empty or being drained this cycle); valid may drop at
// any time without having been accepted.
// Build option: define ARB_LOCK_EN to enable ownership locking.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid_i,
    input  logic [WIDTH-1:0] a_data_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             b_ready_o,
    output logic             y_valid_o,
    output logic [WIDTH-1:0] y_data_o,
    input  logic             y_ready_i,
    output logic             y_src_o,
`ifdef ARB_LOCK_EN
    input  logic             a_lock_i,
    input  logic             b_lock_i,
`endif
    output state_e           dbg_state_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    src_e             y_src_q,  y_src_d;
    logic [1:0]       grant;
    logic             can_load;
    logic             in_xfer;

    assign can_load = (state_q == ST_EMPTY) || y_ready_i;

    // Readies are forced low during reset, since the grant path is purely
    // combinational and would otherwise offer a slot while reset is high.
    assign a_ready_o = grant[0] & can_load & ~reset;
    assign b_ready_o = grant[1] & can_load & ~reset;
    assign in_xfer   = (a_ready_o & a_valid_i) | (b_ready_o & b_valid_i);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({b_valid_i, a_valid_i}),
        .advance (in_xfer),
`ifdef ARB_LOCK_EN
        .lock    (grant[1] ? b_lock_i : a_lock_i),
`endif
        .grant   (grant)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            y_data_q <= '0;
            y_src_q  <= SRC_A;
        end else begin
            state_q  <= state_d;
            y_data_q <= y_data_d;
            y_src_q  <= y_src_d;
        end
    end

    // Next-state logic; a drain and a fresh load in one cycle stays FULL.
    always_comb begin
        state_d  = state_q;
        y_data_d = y_data_q;
        y_src_d  = y_src_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_FULL;
            ST_FULL: begin
                if (in_xfer)        state_d = ST_FULL;
                else if (y_ready_i) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (in_xfer) begin
            y_data_d = grant[1] ? b_data_i : a_data_i;
            y_src_d  = grant[1] ? SRC_B : SRC_A;
        end
    end

    // Output logic
    always_comb begin
        y_valid_o   = (state_q == ST_FULL);
        y_data_o    = y_data_q;
        y_src_o     = y_src_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic         a_lock = 1'b0, b_lock = 1'b0;
    logic         a_ready_o, b_ready_o, y_valid_o, y_src_o;
    logic [W-1:0] y_data_o;
    state_e       dbg_state_o;

    int errors = 0;
    int checks = 0;

    rr_mux_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid_i   (a_valid),
        .a_data_i    (a_data),
        .a_ready_o   (a_ready_o),
        .b_valid_i   (b_valid),
        .b_data_i    (b_data),
        .b_ready_o   (b_ready_o),
        .y_valid_o   (y_valid_o),
        .y_data_o    (y_data_o),
        .y_ready_i   (y_ready),
        .y_src_o     (y_src_o),
`ifdef ARB_LOCK_EN
        .a_lock_i    (a_lock),
        .b_lock_i    (b_lock),
`endif
        .dbg_state_o (dbg_state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model: a queue holding at most the one pending word
    // {src, data}, the source served last, and the current lock owner.
    logic [W:0] exp_q[$];
    int         last_src = 1;   // "B served last" so A wins first contention
    int         owner    = -1;  // -1: no lock owner
    bit         prev_stall = 1'b0;
    logic [W:0] prev_word;

    function automatic int model_grant(input bit av, input bit bv);
        if (owner == 0) return av ? 0 : -1;
        if (owner == 1) return bv ? 1 : -1;
        if (av && bv)   return 1 - last_src;
        if (av)         return 0;
        if (bv)         return 1;
        return -1;
    endfunction

    // Every-cycle monitor, sampled mid-cycle; it also advances the model
    // for the coming rising edge.
    always @(negedge clk) begin
        bit     full, can_load, exp_ar, exp_br, lk;
        int     g;
        state_e exp_st;
        if (reset) begin
            checks++;
            if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0 || y_valid_o !== 1'b0 ||
                y_data_o !== '0 || y_src_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: a_ready=%b b_ready=%b y_valid=%b y_data=%h y_src=%b, required all 0",
                         a_ready_o, b_ready_o, y_valid_o, y_data_o, y_src_o);
            end
            exp_q.delete();
            last_src   = 1;
            owner      = -1;
            prev_stall = 1'b0;
        end else begin
            full     = (exp_q.size() != 0);
            can_load = !full || y_ready;
            g        = model_grant(a_valid, b_valid);
            exp_ar   = (g == 0) && can_load;
            exp_br   = (g == 1) && can_load;
            exp_st   = full ? ST_FULL : ST_EMPTY;

            checks++;
            if (a_ready_o !== exp_ar || b_ready_o !== exp_br) begin
                errors++;
                $display("FAIL ready: a_ready=%b b_ready=%b, required %b %b at %0t",
                         a_ready_o, b_ready_o, exp_ar, exp_br, $time);
            end
            checks++;
            if (a_ready_o === 1'b1 && b_ready_o === 1'b1) begin
                errors++;
                $display("FAIL ready_mutex: a_ready=1 b_ready=1, required at most one at %0t", $time);
            end
            checks++;
            if (y_valid_o !== full || dbg_state_o !== exp_st) begin
                errors++;
                $display("FAIL y_valid: y_valid=%b state=%0d, required %b %0d at %0t",
                         y_valid_o, dbg_state_o, full, exp_st, $time);
            end
            if (full) begin
                checks++;
                if ({y_src_o, y_data_o} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL scoreboard: src=%b data=%h, required src=%b data=%h at %0t",
                             y_src_o, y_data_o, exp_q[0][W], exp_q[0][W-1:0], $time);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({y_valid_o, y_src_o, y_data_o} !== {1'b1, prev_word}) begin
                    errors++;
                    $display("FAIL stall_stable: valid=%b src=%b data=%h, required 1 %b %h at %0t",
                             y_valid_o, y_src_o, y_data_o, prev_word[W], prev_word[W-1:0], $time);
                end
            end
            prev_stall = full && !y_ready;
            prev_word  = {y_src_o, y_data_o};

            if (full && y_ready) void'(exp_q.pop_front());
            if (g >= 0 && can_load) begin
                exp_q.push_back({g[0], (g == 0) ? a_data : b_data});
                last_src = g;
                lk       = (g == 0) ? a_lock : b_lock;
                owner    = lk ? g : -1;
            end
        end
    end

    // Driver tasks
    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
        a_data  = '0;   b_data  = '0;
        a_lock  = 1'b0; b_lock  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        b_valid = 1'b1; b_data = 8'h5A; y_ready = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (y_valid_o !== 1'b1 || y_src_o !== 1'b1 || y_data_o !== 8'h5A) begin
            errors++;
            $display("FAIL reset_precondition: valid=%b src=%b data=%h, required 1 1 5a",
                     y_valid_o, y_src_o, y_data_o);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (y_valid_o !== 1'b0 || y_data_o !== 8'h00 || y_src_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: valid=%b data=%h src=%b, required 0 00 0",
                     y_valid_o, y_data_o, y_src_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_d;
        do_reset();
        a_valid = 1'b1; a_data = 8'h11;
        b_valid = 1'b1; b_data = 8'h22;
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
            checks++;
            if (y_valid_o !== 1'b1 || y_data_o !== exp_d) begin
                errors++;
                $display("FAIL contention[%0d]: valid=%b data=%h, required 1 %h", i, y_valid_o, y_data_o, exp_d);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1'b1; a_data = 8'hA5;
        b_valid = 1'b1; b_data = 8'hB6;
        y_ready = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (y_valid_o !== 1'b1 || y_data_o !== 8'hA5 || y_src_o !== 1'b0 ||
                a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h src=%b a_ready=%b b_ready=%b, required 1 a5 0 0 0",
                         k, y_valid_o, y_data_o, y_src_o, a_ready_o, b_ready_o);
            end
            @(posedge clk); #1;
        end
        y_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: b_ready=%b, required 1", b_ready_o);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (y_valid_o !== 1'b1 || y_data_o !== 8'hB6 || y_src_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_next: valid=%b data=%h src=%b, required 1 b6 1", y_valid_o, y_data_o, y_src_o);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_single_requester();
        do_reset();
        b_valid = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data = W'(i + 1);
            @(negedge clk);
            checks++;
            if (b_ready_o !== 1'b1 || a_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL single_grant[%0d]: a_ready=%b b_ready=%b, required 0 1", i, a_ready_o, b_ready_o);
            end
            if (i > 0) begin
                checks++;
                if (y_valid_o !== 1'b1 || y_data_o !== W'(i) || y_src_o !== 1'b1) begin
                    errors++;
                    $display("FAIL single_out[%0d]: valid=%b data=%h src=%b, required 1 %h 1",
                             i, y_valid_o, y_data_o, y_src_o, W'(i));
                end
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (y_valid_o !== 1'b1 || y_data_o !== 8'h04 || y_src_o !== 1'b1) begin
            errors++;
            $display("FAIL single_last: valid=%b data=%h src=%b, required 1 04 1", y_valid_o, y_data_o, y_src_o);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        b_valid = 1'b1; b_data = 8'hBB; y_ready = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = W'(8'hA0 + i);
            a_lock = (i < 3);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (y_data_o !== W'(8'hA0 + i - 1) || y_src_o !== 1'b0 || b_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_seq[%0d]: data=%h src=%b b_ready=%b, required %h 0 0",
                             i, y_data_o, y_src_o, b_ready_o, W'(8'hA0 + i - 1));
                end
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0; a_lock = 1'b0;
        @(negedge clk);
        checks++;
        if (y_data_o !== 8'hA3 || y_src_o !== 1'b0 || b_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_release: data=%h src=%b b_ready=%b, required a3 0 1", y_data_o, y_src_o, b_ready_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (y_data_o !== 8'hBB || y_src_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_then_b: data=%h src=%b, required bb 1", y_data_o, y_src_o);
        end
        // Owner goes idle while holding the lock; B must stay blocked.
        a_valid = 1'b1; a_lock = 1'b1; a_data = 8'hC1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (b_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL lock_idle_owner[%0d]: b_ready=%b, required 0", k, b_ready_o);
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b1; a_lock = 1'b0; a_data = 8'hC2;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (y_data_o !== 8'hC2 || b_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_idle_release: data=%h b_ready=%b, required c2 1", y_data_o, b_ready_o);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_data  = W'($urandom);
            b_data  = W'($urandom);
            y_ready = ($urandom_range(0, 9) < 7);
`ifdef ARB_LOCK_EN
            a_lock  = ($urandom_range(0, 2) == 0);
            b_lock  = ($urandom_range(0, 2) == 0);
`endif
            reset   = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle_inputs();
        y_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_backpressure();
        test_single_requester();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
